// File: rtl/uart_pkg.sv
// Shared UART framing definitions: byte width, byte-order selector and a
// constant-evaluable ceil(log2) used to size ports and counters.
package uart_pkg;

  localparam int UART_BYTE_W = 8;

  typedef enum logic {
    BYTE_ORDER_LSB_FIRST = 1'b0,
    BYTE_ORDER_MSB_FIRST = 1'b1
  } byte_order_e;

  function automatic int clog2(input int value);
    int res;
    res = 0;
    while ((1 << res) < value) begin
      res++;
    end
    return res;
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO: head_data shows the oldest entry whenever the
// FIFO is not empty, and reads zero while empty.
module sync_fifo_fwft
  import uart_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  pop,
  output logic [WIDTH-1:0]      head_data,
  output logic                  empty,
  output logic                  full,
  output logic [clog2(DEPTH):0] level
);

  localparam int PTR_W = clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
  logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]            rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]            level_q, level_d;
  logic                        do_push, do_pop;

  assign empty     = (level_q == '0);
  assign full      = (level_q == LVL_W'(DEPTH));
  assign level     = level_q;
  assign head_data = empty ? '0 : mem_q[rd_ptr_q];

  // A push into a full FIFO only lands when the head leaves on the same edge.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

// File: rtl/uart_word_packer.sv
// Packs BYTES_PER_WORD UART bytes into one word, with stale-byte timeout,
// resync, and an output FIFO carrying a sticky overflow flag.
module uart_word_packer
  import uart_pkg::*;
#(
  parameter int BYTES_PER_WORD = 4,
  parameter bit MSB_FIRST      = 1'b1,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [UART_BYTE_W-1:0]                rx_data,
  input  logic                                  rx_data_valid,
  input  logic                                  resync,
  input  logic                                  clr_err,
  output logic [UART_BYTE_W*BYTES_PER_WORD-1:0] word_data,
  output logic                                  word_valid,
  input  logic                                  word_ready,
  output logic [clog2(FIFO_DEPTH):0]            fifo_level,
  output logic [clog2(BYTES_PER_WORD)-1:0]      byte_idx,
  output logic                                  timeout_pulse,
  output logic                                  overflow
);

  localparam int                WORD_W     = UART_BYTE_W * BYTES_PER_WORD;
  localparam int                BIDX_W     = clog2(BYTES_PER_WORD);
  localparam logic [BIDX_W-1:0] LAST_IDX   = BIDX_W'(BYTES_PER_WORD - 1);
  localparam int                TMO_LOAD_I = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam int                CNT_W      = (clog2(TMO_LOAD_I + 1) > 0) ? clog2(TMO_LOAD_I + 1) : 1;
  localparam logic [CNT_W-1:0]  TMO_LOAD   = CNT_W'(TMO_LOAD_I);
  localparam byte_order_e       ORDER      = MSB_FIRST ? BYTE_ORDER_MSB_FIRST : BYTE_ORDER_LSB_FIRST;

  typedef logic [BYTES_PER_WORD-1:0][UART_BYTE_W-1:0] word_t;

  word_t             asm_q, asm_d;
  word_t             cur_asm, push_word;
  logic [BIDX_W-1:0] byte_idx_q, byte_idx_d;
  logic [BIDX_W-1:0] cur_idx, slot;
  logic [CNT_W-1:0]  idle_cnt_q, idle_cnt_d;
  logic              timeout_pulse_q, timeout_pulse_d;
  logic              overflow_q, overflow_d;
  logic              push_req;
  logic              fifo_pop, fifo_full, fifo_empty;

  assign word_valid    = !fifo_empty;
  assign fifo_pop      = word_valid && word_ready;
  assign byte_idx      = byte_idx_q;
  assign timeout_pulse = timeout_pulse_q;
  assign overflow      = overflow_q;

  always_comb begin
    asm_d           = asm_q;
    byte_idx_d      = byte_idx_q;
    idle_cnt_d      = idle_cnt_q;
    timeout_pulse_d = 1'b0;
    overflow_d      = overflow_q && !clr_err;
    push_req        = 1'b0;
    push_word       = '0;
    // A byte arriving with resync starts a fresh word at slot 0.
    cur_idx         = resync ? '0 : byte_idx_q;
    cur_asm         = resync ? '0 : asm_q;
    slot            = (ORDER == BYTE_ORDER_MSB_FIRST) ? LAST_IDX - cur_idx : cur_idx;

    if (resync) begin
      asm_d      = '0;
      byte_idx_d = '0;
      idle_cnt_d = '0;
    end

    if (rx_data_valid) begin
      push_word       = cur_asm;
      push_word[slot] = rx_data;
      if (cur_idx == LAST_IDX) begin
        push_req   = 1'b1;
        asm_d      = '0;
        byte_idx_d = '0;
        idle_cnt_d = '0;
      end else begin
        asm_d      = push_word;
        byte_idx_d = cur_idx + BIDX_W'(1);
        idle_cnt_d = TMO_LOAD;
      end
    end else if (!resync && (byte_idx_q != '0) && (TIMEOUT_CYCLES != 0)) begin
      if (idle_cnt_q == '0) begin
        asm_d           = '0;
        byte_idx_d      = '0;
        timeout_pulse_d = 1'b1;
      end else begin
        idle_cnt_d = idle_cnt_q - CNT_W'(1);
      end
    end

    if (push_req && fifo_full && !fifo_pop) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      asm_q           <= '0;
      byte_idx_q      <= '0;
      idle_cnt_q      <= '0;
      timeout_pulse_q <= 1'b0;
      overflow_q      <= 1'b0;
    end else begin
      asm_q           <= asm_d;
      byte_idx_q      <= byte_idx_d;
      idle_cnt_q      <= idle_cnt_d;
      timeout_pulse_q <= timeout_pulse_d;
      overflow_q      <= overflow_d;
    end
  end

  sync_fifo_fwft #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_req),
    .push_data (push_word),
    .pop       (fifo_pop),
    .head_data (word_data),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .level     (fifo_level)
  );

endmodule

// File: doc/uart_word_packer.md
Name: uart_word_packer

Overview:
- Parametrised successor to the 2-byte UART concatenator: packs BYTES_PER_WORD consecutive UART bytes into one word.
- Adds:
  - selectable byte order;
  - an inter-byte timeout that discards stale partial words;
  - an explicit resync input;
  - a small output FIFO with a valid/ready handshake.
- Sits between the UART receiver and the order-parsing logic.

Parameters:
- BYTES_PER_WORD, 4, bytes per output word; legal range 2..8.
- MSB_FIRST, 1, 1: first received byte lands in the top byte of word_data; 0: first byte lands in bits [7:0].
- TIMEOUT_CYCLES, 100000, idle clocks allowed between bytes of one word; 0 disables the timeout.
- FIFO_DEPTH, 4, output FIFO entries; power of 2, minimum 2.

Ports:
- clk  in  1  system clock, all logic on the rising edge.
- rst  in  1  synchronous active-high reset.
- rx_data  in  8  byte from UART RX.
- rx_data_valid  in  1  one-cycle strobe qualifying rx_data.
- resync  in  1  discards any partial word.
- clr_err  in  1  clears the sticky overflow flag.
- word_data  out  8*BYTES_PER_WORD  FIFO head word.
- word_valid  out  1  FIFO not empty.
- word_ready  in  1  consumer accepts the head word when word_valid is also high.
- fifo_level  out  clog2(FIFO_DEPTH)+1  entries currently held.
- byte_idx  out  clog2(BYTES_PER_WORD)  bytes held in the partial word.
- timeout_pulse  out  1  one-cycle pulse when a partial word is discarded by the timeout.
- overflow  out  1  sticky; a completed word was dropped because the FIFO was full.

Behaviour:
- Reset (synchronous, rst high at a clk edge):
  - assembly register = 0, byte_idx = 0, idle counter = 0;
  - FIFO emptied: word_valid = 0, fifo_level = 0, word_data = 0;
  - timeout_pulse = 0, overflow = 0.
  - rst overrides every other input, including a byte arriving in the same cycle.
- Assembly (no FSM beyond byte_idx, values 0..BYTES_PER_WORD-1):
  - on rx_data_valid with byte_idx < BYTES_PER_WORD-1: store the byte in its slot, then byte_idx + 1;
  - slot for arrival k: MSB_FIRST=1 puts it at bits [8*(N-1-k)+7 : 8*(N-1-k)]; MSB_FIRST=0 puts it at [8k+7 : 8k];
  - on the final byte: the full word (including this byte) is pushed to the FIFO in the same edge, and byte_idx returns to 0.
- Latency: word_valid rises the cycle after the final byte's rx_data_valid cycle, when the FIFO was empty.
- FIFO:
  - first-word-fall-through; word_data is valid whenever word_valid is high;
  - pop occurs when word_valid && word_ready;
  - push while full is accepted only if a pop happens in the same cycle;
  - push and pop in the same cycle leave fifo_level unchanged.
- Overflow: a completed word arriving while the FIFO is full with no simultaneous pop is dropped; overflow is set and byte_idx returns to 0.
- overflow clear: cleared by clr_err or rst. If clr_err and a new overflow coincide, overflow stays set.
- Timeout:
  - the idle counter runs only while byte_idx != 0;
  - it resets to 0 on every accepted byte;
  - when it reaches TIMEOUT_CYCLES-1 with no byte that cycle: partial word discarded, byte_idx = 0, timeout_pulse = 1 for one cycle.
  - A byte arriving on the expiry cycle wins: it is accepted and no timeout occurs.
- resync:
  - discards the partial word and clears the idle counter;
  - a byte arriving in the same cycle becomes byte 0 of a new word, so byte_idx = 1;
  - resync does not affect FIFO contents.
- Discarded partial bytes are never emitted.

Decomposition:
- uart_pkg holds:
  - constant UART_BYTE_W = 8;
  - a clog2 function;
  - typedef for the byte-order enum (MSB_FIRST / LSB_FIRST) shared with the future word unpacker for TX.
- One sub-module, sync_fifo_fwft:
  - parameters WIDTH and DEPTH;
  - ports: push, push_data, pop, head_data, empty, full, level;
  - synchronous active-high rst.

Test Plan:
- N=4, MSB_FIRST=1, bytes 0xDE 0xAD 0xBE 0xEF on consecutive cycles, word_ready=1 → word_data=0xDEADBEEF with word_valid high for one cycle, exactly 1 cycle after the 0xEF strobe.
- MSB_FIRST=0, same bytes → word_data=0xEFBEADDE; also run N=2 → 0xADDE.
- TIMEOUT_CYCLES=10: send 0x11 0x22, idle 10 cycles → timeout_pulse once and byte_idx=0. Then send 0x33 0x44 0x55 0x66 → word 0x33445566 with no 0x11/0x22 leakage. Repeat with the byte landing on the expiry cycle → no pulse, byte_idx=3.
- FIFO_DEPTH=4, word_ready=0, send 5 words → fifo_level=4 and overflow=1 after the 5th. Then raise ready → 4 words drained in order and the 5th absent. Pulse clr_err → overflow=0.
- Full FIFO with word_ready=1 on the same cycle as the final byte → no overflow, fifo_level stays 4.
- resync together with byte 0xAA after 2 stored bytes → byte_idx=1; the next 3 bytes form a word starting with 0xAA. Assert rst mid-word with 2 words queued → all outputs 0 on the next cycle.
